// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C transaction arbiter.
//   arb_state_t  arbiter FSM state encoding
//   I2C_ADDR_W   7-bit slave address width
//   I2C_DATA_W   single-byte data width
//   ERR_*        response error codes returned with rsp_valid
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } arb_state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority picker. Selects the first asserted request at or
// after the pointer, wrapping NUM_REQ-1 -> 0.
//   req_i   request vector
//   ptr_i   highest-priority index this round
//   gnt_o   one-hot winner (all zero when no request)
//   vld_o   at least one request present
//   idx_o   binary index of the winner
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       vld_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  always_comb begin
    logic             found;
    logic [IDX_W:0]   pos;
    found = 1'b0;
    pos   = '0;
    idx_o = '0;
    gnt_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit so the wrap works for non-power-of-two NUM_REQ.
      pos = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (pos >= NUM_REQ_W) pos = pos - NUM_REQ_W;
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx_o = pos[IDX_W-1:0];
      end
    end
    if (found) gnt_o[idx_o] = 1'b1;
    vld_o = found;
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one single-byte I2C master between NUM_REQ requesters.
// Round-robin winner selection, one transaction at a time, timeout abort, result
// returned to the winner as a one-cycle rsp_valid pulse.
// Optional build macro I2C_ARB_RETRY_EN: re-launch on NACK up to MAX_RETRY times.
// Ports:
//   clk_400, rst                    clock, synchronous active-high reset
//   req/req_rw/req_addr/req_wdata   per-requester request level and fields
//   gnt, rsp_valid                  one-hot pulses to the winner
//   rsp_rdata, rsp_err, arb_busy    result byte, error code, transaction in flight
//   m_start_txn/m_rw/m_sub_addr/m_data_in   command to the master
//   m_busy/m_done/m_ack_error/m_data_out    status from the master
//
// state        | meaning
// ST_IDLE      | waiting for a request with the master quiet; picks winner
// ST_LAUNCH    | start pulse (and gnt on first attempt); clears timer
// ST_WAIT_BUSY | waiting for master to accept (m_busy)
// ST_WAIT_DONE | waiting for rising edge of m_done
// ST_RESP      | rsp_valid pulse; advance pointer past winner
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 512,
  parameter int MAX_RETRY   = 2
) (
  input  logic                           clk_400,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_rw,
  input  logic [I2C_ADDR_W*NUM_REQ-1:0]  req_addr,
  input  logic [I2C_DATA_W*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [I2C_DATA_W-1:0]          rsp_rdata,
  output logic [1:0]                     rsp_err,
  output logic                           arb_busy,
  output logic                           m_start_txn,
  output logic                           m_rw,
  output logic [I2C_ADDR_W-1:0]          m_sub_addr,
  output logic [I2C_DATA_W-1:0]          m_data_in,
  input  logic                           m_busy,
  input  logic                           m_done,
  input  logic                           m_ack_error,
  input  logic [I2C_DATA_W-1:0]          m_data_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  arb_state_t              state_q;
  logic [IDX_W-1:0]        ptr_q, win_q;
  logic                    rw_q;
  logic [I2C_ADDR_W-1:0]   addr_q;
  logic [I2C_DATA_W-1:0]   wdata_q, rdata_q;
  logic [TMR_W-1:0]        tmr_q;
  logic                    done_q, start_q, busy_q;
  logic [NUM_REQ-1:0]      gnt_q, rsp_valid_q;
  logic [1:0]              err_q;

  logic [NUM_REQ-1:0]      arb_oh;
  logic                    arb_vld;
  logic [IDX_W-1:0]        arb_idx;
  logic [I2C_ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [I2C_DATA_W-1:0]   wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0]      win_oh;
  logic [IDX_W:0]          ptr_inc;
  logic                    done_edge, tmo_hit, retry_now;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[I2C_ADDR_W*g +: I2C_ADDR_W];
    assign wdata_arr[g] = req_wdata[I2C_DATA_W*g +: I2C_DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_oh),
    .vld_o (arb_vld),
    .idx_o (arb_idx)
  );

  assign win_oh    = NUM_REQ'(1) << win_q;
  assign ptr_inc   = {1'b0, win_q} + 1'b1;
  assign done_edge = m_done && !done_q;
  assign tmo_hit   = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

`ifdef I2C_ARB_RETRY_EN
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RTY_W-1:0] retry_q;

  assign retry_now = m_ack_error && (retry_q < RTY_W'(MAX_RETRY));

  // Attempt count belongs to one winner; cleared whenever the arbiter is idle.
  always_ff @(posedge clk_400) begin
    if (rst || state_q == ST_IDLE) retry_q <= '0;
    else if (state_q == ST_WAIT_DONE && done_edge && retry_now) retry_q <= retry_q + 1'b1;
  end
`else
  logic unused_max_retry;
  assign unused_max_retry = |MAX_RETRY;
  assign retry_now        = 1'b0;
`endif

  always_ff @(posedge clk_400) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= ERR_OK;
      tmr_q       <= '0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      done_q      <= m_done;
      gnt_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_vld && !m_busy && !m_done) begin
            win_q   <= arb_idx;
            rw_q    <= req_rw[arb_idx];
            addr_q  <= addr_arr[arb_idx];
            wdata_q <= wdata_arr[arb_idx];
            gnt_q   <= arb_oh;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tmr_q   <= '0;
          state_q <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tmo_hit) begin
            rsp_valid_q <= win_oh;
            err_q       <= ERR_TMO;
            rdata_q     <= '0;
            state_q     <= ST_RESP;
          end else begin
            tmr_q <= tmr_q + 1'b1;
            if (m_busy) state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          // A completion on the timeout cycle wins, so a NACK is never reported as a timeout.
          if (done_edge) begin
            if (retry_now) begin
              start_q <= 1'b1;
              state_q <= ST_LAUNCH;
            end else begin
              rsp_valid_q <= win_oh;
              err_q       <= m_ack_error ? ERR_NACK : ERR_OK;
              rdata_q     <= rw_q ? m_data_out : '0;
              state_q     <= ST_RESP;
            end
          end else if (tmo_hit) begin
            rsp_valid_q <= win_oh;
            err_q       <= ERR_TMO;
            rdata_q     <= '0;
            state_q     <= ST_RESP;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_RESP: begin
          ptr_q   <= (ptr_inc == (IDX_W + 1)'(NUM_REQ)) ? '0 : ptr_inc[IDX_W-1:0];
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign arb_busy    = busy_q;
  assign m_start_txn = start_q;
  assign m_rw        = rw_q;
  assign m_sub_addr  = addr_q;
  assign m_data_in   = wdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
module tb_i2c_txn_arbiter;

  localparam int N    = 4;
  localparam int TMO  = 64;
  localparam int MAXR = 2;
`ifdef I2C_ARB_RETRY_EN
  localparam int NACK_TRIES = MAXR + 1;
`else
  localparam int NACK_TRIES = 1;
`endif

  logic            clk_400 = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_rw, gnt, rsp_valid;
  logic [7*N-1:0]  req_addr;
  logic [8*N-1:0]  req_wdata;
  logic [7:0]      rsp_rdata, m_data_in, m_data_out;
  logic [1:0]      rsp_err;
  logic            arb_busy, m_start_txn, m_rw, m_busy, m_done, m_ack_error;
  logic [6:0]      m_sub_addr;

  always #5 clk_400 = ~clk_400;

  int cyc = 0;
  always @(posedge clk_400) cyc <= cyc + 1;

  i2c_txn_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
    .clk_400(clk_400), .rst(rst),
    .req(req), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .arb_busy(arb_busy), .m_start_txn(m_start_txn), .m_rw(m_rw),
    .m_sub_addr(m_sub_addr), .m_data_in(m_data_in),
    .m_busy(m_busy), .m_done(m_done), .m_ack_error(m_ack_error), .m_data_out(m_data_out)
  );

  // Reference state: requester table, round-robin pointer, slave memory.
  int          p_model;
  logic [N-1:0] mask;
  logic        rw_a   [N];
  logic [6:0]  addr_a [N];
  logic [7:0]  wd_a   [N];
  logic [7:0]  mem    [128];
  bit          hold;
  int          n_starts, done_cyc;
  int          n_chk, n_pass;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_req();
    req = mask;
    for (int i = 0; i < N; i++) begin
      req_rw[i]          = rw_a[i];
      req_addr[7*i +: 7] = addr_a[i];
      req_wdata[8*i +: 8] = wd_a[i];
    end
  endtask

  task automatic set_req(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
    mask[i] = 1'b1; rw_a[i] = rw; addr_a[i] = a; wd_a[i] = d;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
  endtask

  function automatic int model_pick();
    for (int k = 0; k < N; k++)
      if (mask[(p_model + k) % N]) return (p_model + k) % N;
    return 0;
  endfunction

  task automatic reshuffle(input int w);
    for (int i = 0; i < N; i++) begin
      if (i == w || !mask[i]) begin
        if ($urandom_range(0, 1) == 1) rand_req(i);
        else mask[i] = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        mask[i] = 1'b0;
      end
    end
    if (mask == '0) rand_req($urandom_range(0, N - 1));
  endtask

  // Behavioural master + slave: slave NACKs addresses 0x70..0x7F, reads return mem[addr].
  initial begin : master_model
    int         len;
    logic       mrw, nk;
    logic [6:0] maddr;
    m_busy = 0; m_done = 0; m_ack_error = 0; m_data_out = 0;
    forever begin
      @(negedge clk_400);
      m_done = 0; m_ack_error = 0;
      if (m_start_txn === 1'b1) begin
        n_starts++;
        mrw = m_rw; maddr = m_sub_addr;
        @(negedge clk_400);
        m_busy = 1;
        if (hold) begin
          while (hold) @(negedge clk_400);
          m_busy = 0;
        end else begin
          len = $urandom_range(1, 10);
          repeat (len) @(negedge clk_400);
          nk = (maddr[6:4] == 3'b111);
          m_busy = 0; m_done = 1; m_ack_error = nk;
          m_data_out = nk ? 8'h00 : (mrw ? mem[maddr] : 8'($urandom));
          done_cyc = cyc;
        end
      end
    end
  end

  // mode: 0 = reshuffle requests after grant, 1 = winner drops req, 2 = all held
  task automatic run_txn(input string tag, input int mode);
    int w, t, g_cyc, s0, gnt_extra;
    logic nack;
    logic [1:0] e_err;
    logic [7:0] e_rd;
    int e_starts;
    drive_req();
    w  = model_pick();
    s0 = n_starts;
    t  = 0;
    while (gnt == '0 && t < 300) begin @(negedge clk_400); t++; end
    g_cyc = cyc;
    check_eq({tag, "_gnt"},   32'(gnt), 32'(1) << w);
    check_eq({tag, "_start"}, 32'(m_start_txn), 32'd1);
    check_eq({tag, "_cmd"},   32'({m_rw, m_sub_addr, m_data_in}), 32'({rw_a[w], addr_a[w], wd_a[w]}));
    nack     = (addr_a[w][6:4] == 3'b111);
    e_err    = hold ? 2'b10 : (nack ? 2'b01 : 2'b00);
    e_rd     = (hold || nack || !rw_a[w]) ? 8'h00 : mem[addr_a[w]];
    e_starts = (!hold && nack) ? NACK_TRIES : 1;
    if (mode == 0) reshuffle(w);
    else if (mode == 1) mask[w] = 1'b0;
    drive_req();
    t = 0; gnt_extra = 0;
    do begin
      @(negedge clk_400); t++;
      if (gnt != '0) gnt_extra++;
    end while (rsp_valid == '0 && t < 400);
    check_eq({tag, "_rspv"},   32'(rsp_valid), 32'(1) << w);
    check_eq({tag, "_err"},    32'(rsp_err), 32'(e_err));
    check_eq({tag, "_rdata"},  32'(rsp_rdata), 32'(e_rd));
    check_eq({tag, "_busy"},   32'(arb_busy), 32'd1);
    check_eq({tag, "_starts"}, 32'(n_starts - s0), 32'(e_starts));
    check_eq({tag, "_regnt"},  32'(gnt_extra), 32'd0);
    if (hold) check_eq({tag, "_tmo_lat"}, 32'(cyc - g_cyc), 32'(TMO + 1));
    else      check_eq({tag, "_lat"},     32'(cyc - done_cyc), 32'd1);
    p_model = (w + 1) % N;
    if (hold) begin
      hold = 0;
      t = 0;
      while (m_busy && t < 20) begin @(negedge clk_400); t++; end
    end
  endtask

  initial begin
    int cnt;
    n_chk = 0; n_pass = 0; n_starts = 0; done_cyc = 0; hold = 0; p_model = 0;
    mask = '0;
    for (int i = 0; i < N; i++) begin rw_a[i] = 0; addr_a[i] = 0; wd_a[i] = 0; end
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[7'h3C] = 8'h5A;
    rst = 1;
    drive_req();
    repeat (3) @(negedge clk_400);
    check_eq("rst_outs_a", 32'({gnt, rsp_valid, arb_busy, m_start_txn, m_rw, m_sub_addr}), 32'd0);
    check_eq("rst_outs_b", 32'({m_data_in, rsp_rdata, rsp_err}), 32'd0);
    rst = 0;
    @(negedge clk_400);

    set_req(1, 1'b0, 7'h50, 8'hA5);
    run_txn("wr1", 1);
    repeat (3) @(negedge clk_400);

    set_req(2, 1'b1, 7'h3C, 8'h00);
    run_txn("rd2", 1);
    repeat (3) @(negedge clk_400);

    rst = 1; repeat (2) @(negedge clk_400); rst = 0; p_model = 0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 7'(8'h10 + 8'(i)), 8'(8'hC0 + 8'(i)));
    for (int r = 0; r < 5; r++) run_txn("rr_all", 2);
    mask = '0; drive_req();
    repeat (3) @(negedge clk_400);

    set_req(0, 1'b0, 7'h71, 8'h11);
    run_txn("nack", 1);
    repeat (3) @(negedge clk_400);

    hold = 1;
    set_req(1, 1'b1, 7'h22, 8'h00);
    run_txn("tmo", 1);
    repeat (3) @(negedge clk_400);

    hold = 1;
    set_req(2, 1'b0, 7'h12, 8'h34);
    drive_req();
    cnt = 0;
    while (gnt == '0 && cnt < 300) begin @(negedge clk_400); cnt++; end
    check_eq("mid_gnt", 32'(gnt), 32'b0100);
    mask = '0; drive_req();
    repeat (6) @(negedge clk_400);
    check_eq("mid_busy", 32'(arb_busy), 32'd1);
    rst = 1;
    @(negedge clk_400);
    rst = 0;
    check_eq("mid_rst_a", 32'({gnt, rsp_valid, arb_busy, m_start_txn, m_rw, m_sub_addr}), 32'd0);
    check_eq("mid_rst_b", 32'({m_data_in, rsp_rdata, rsp_err}), 32'd0);
    cnt = 0;
    repeat (10) begin @(negedge clk_400); if (rsp_valid != '0) cnt++; end
    check_eq("mid_no_rsp", 32'(cnt), 32'd0);
    hold = 0;
    p_model = 0;
    cnt = 0;
    while (m_busy && cnt < 20) begin @(negedge clk_400); cnt++; end
    for (int i = 0; i < N; i++) rand_req(i);
    run_txn("after_rst", 0);

    for (int k = 0; k < 40; k++) begin
      hold = ($urandom_range(0, 9) == 0);
      run_txn("rand", 0);
    end
    mask = '0; drive_req();
    repeat (5) @(negedge clk_400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
